// File: rtl/conv_window_sched_if.sv
// Handshake bundle between conv_window_sched, the layer controller, window mux, conv engine and output store.
// The master modport is the scheduler's view; the slave modport is the surrounding datapath's view.
interface conv_window_sched_if #(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8
);
  localparam int OUT_N = SIZE - SIZEKer + 1;
  localparam int IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  logic                        start;
  logic                        abort;
  logic                        busy;
  logic                        done;
  logic        [IDX_W-1:0]     win_row;
  logic        [IDX_W-1:0]     win_col;
  logic                        win_load;
  logic                        eng_start;
  logic                        eng_done;
  logic signed [WIDTH_BIT-1:0] eng_result;
  logic                        out_we;
  logic                        out_ready;
  logic        [IDX_W-1:0]     out_row;
  logic        [IDX_W-1:0]     out_col;
  logic signed [WIDTH_BIT-1:0] out_data;

  modport master (
    input  start, abort, eng_done, eng_result, out_ready,
    output busy, done, win_row, win_col, win_load, eng_start,
           out_we, out_row, out_col, out_data
  );

  modport slave (
    output start, abort, eng_done, eng_result, out_ready,
    input  busy, done, win_row, win_col, win_load, eng_start,
           out_we, out_row, out_col, out_data
  );
endinterface

// File: rtl/conv_window_sched.sv
// Window-origin sequencer for the shared convolution engine: LOAD, RUN, WAIT, WRITE per output, row-major.
// Define CONV_WINDOW_SCHED_RELU_EN to apply ReLU plus arithmetic halving to every engine result.
module conv_window_sched #(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8
) (
  input logic                 clock,
  input logic                 reset,
  conv_window_sched_if.master bus
);
  localparam int OUT_N = SIZE - SIZEKer + 1;
  localparam int IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(OUT_N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                      state_q, state_d;
  logic        [IDX_W-1:0]     row_q, row_d;
  logic        [IDX_W-1:0]     col_q, col_d;
  logic signed [WIDTH_BIT-1:0] res_q, res_d;

  function automatic logic signed [WIDTH_BIT-1:0] post_proc(input logic signed [WIDTH_BIT-1:0] r);
`ifdef CONV_WINDOW_SCHED_RELU_EN
    post_proc = (r >= 0) ? (r >>> 1) : '0;
`else
    post_proc = r;
`endif
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    res_d   = res_q;
    // abort beats everything, including a write being accepted in the same cycle
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      row_d   = '0;
      col_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          row_d = '0;
          col_d = '0;
          if (bus.start) state_d = S_LOAD;
        end
        S_LOAD: state_d = S_RUN;
        S_RUN:  state_d = S_WAIT;
        S_WAIT: begin
          if (bus.eng_done) begin
            res_d   = post_proc(bus.eng_result);
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.out_ready) begin
            if ((row_q == LAST) && (col_q == LAST)) begin
              state_d = S_DONE;
            end else if (col_q == LAST) begin
              col_d   = '0;
              row_d   = row_q + IDX_W'(1);
              state_d = S_LOAD;
            end else begin
              col_d   = col_q + IDX_W'(1);
              state_d = S_LOAD;
            end
          end
        end
        S_DONE: begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_IDLE;
        end
        default: begin
          row_d   = '0;
          col_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.win_load  = (state_q == S_LOAD);
  assign bus.eng_start = (state_q == S_RUN);
  assign bus.out_we    = (state_q == S_WRITE);
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_data  = res_q;
endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: engine responder pushes expected results, monitor pops on each accepted write.
// Build with or without CONV_WINDOW_SCHED_RELU_EN; the reference post-processing follows the same macro.
module tb_conv_window_sched;
  localparam int SIZE      = 7;
  localparam int SIZEKER   = 3;
  localparam int WIDTH_BIT = 8;
  localparam int OUT_N     = SIZE - SIZEKER + 1;

  logic clk;
  logic reset;
  int   cyc;

  conv_window_sched_if #(.SIZE(SIZE), .SIZEKer(SIZEKER), .WIDTH_BIT(WIDTH_BIT)) bus ();

  conv_window_sched #(.SIZE(SIZE), .SIZEKer(SIZEKER), .WIDTH_BIT(WIDTH_BIT)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  int exp_row_q[$];
  int exp_col_q[$];
  int exp_data_q[$];
  int forced_q[$];

  int eng_delay  = 1;
  bit spur_en    = 1'b0;
  int ready_mode = 0;
  int stall_left = 0;
  int writes_done = 0;
  int stall_seen  = 0;
  int done_cnt    = 0;
  int start_cyc   = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference post-processing written from the arithmetic rule, not the shift form.
  function automatic int ref_post(input int v);
`ifdef CONV_WINDOW_SCHED_RELU_EN
    if (v < 0) return 0;
    return v / 2;
`else
    return v;
`endif
  endfunction

  // Engine model: answers each eng_start after eng_delay cycles; optional spurious pulse during LOAD.
  initial begin
    int v;
    bus.eng_done   = 1'b0;
    bus.eng_result = '0;
    forever begin
      @(negedge clk);
      bus.eng_done = 1'b0;
      if (spur_en && bus.win_load) begin
        bus.eng_done   = 1'b1;
        bus.eng_result = WIDTH_BIT'(77);
      end else if (bus.eng_start && !reset) begin
        v = (forced_q.size() > 0) ? forced_q.pop_front() : int'($urandom_range(255)) - 128;
        repeat (eng_delay) @(negedge clk);
        bus.eng_done   = 1'b1;
        bus.eng_result = WIDTH_BIT'(v);
        exp_data_q.push_back(ref_post(v));
      end
    end
  end

  // Output-store model driving out_ready.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: begin
          if (bus.out_we && (writes_done == 2 * OUT_N + 3) && (stall_left > 0)) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        2: bus.out_ready = ($urandom_range(3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pop on accepted writes, hold-stability while stalled.
  initial begin
    bit pend;
    int p_row, p_col, p_dat;
    pend = 1'b0;
    p_row = 0; p_col = 0; p_dat = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (bus.done) done_cnt++;
        if (bus.win_load && (exp_row_q.size() > 0)) begin
          chk("win_row_at_load", bus.win_row, exp_row_q[0]);
          chk("win_col_at_load", bus.win_col, exp_col_q[0]);
        end
        if (pend) begin
          chk("hold_out_we", bus.out_we, 1);
          chk("hold_out_row", bus.out_row, p_row);
          chk("hold_out_col", bus.out_col, p_col);
          chk("hold_out_data", bus.out_data, p_dat);
        end
        if (bus.out_we && bus.out_ready && !bus.abort) begin
          pend = 1'b0;
          chk("sb_has_entry", int'((exp_data_q.size() > 0) && (exp_row_q.size() > 0)), 1);
          if ((exp_data_q.size() > 0) && (exp_row_q.size() > 0)) begin
            chk("out_row", bus.out_row, exp_row_q.pop_front());
            chk("out_col", bus.out_col, exp_col_q.pop_front());
            chk("out_data", bus.out_data, exp_data_q.pop_front());
          end
          writes_done++;
        end else if (bus.out_we) begin
          stall_seen++;
          pend  = 1'b1;
          p_row = bus.out_row;
          p_col = bus.out_col;
          p_dat = bus.out_data;
        end else begin
          pend = 1'b0;
        end
      end
    end
  end

  task automatic flush();
    exp_row_q.delete();
    exp_col_q.delete();
    exp_data_q.delete();
    forced_q.delete();
  endtask

  task automatic start_pass();
    writes_done = 0;
    stall_seen  = 0;
    for (int r = 0; r < OUT_N; r++)
      for (int c = 0; c < OUT_N; c++) begin
        exp_row_q.push_back(r);
        exp_col_q.push_back(c);
      end
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc;
  endtask

  // exp_len <= 0 skips the latency comparison (random backpressure).
  task automatic wait_done(input int exp_len, input bit noise);
    bit seen;
    int d0;
    seen = 1'b0;
    d0   = done_cnt;
    for (int n = 0; (n < 3000) && !seen; n++) begin
      @(negedge clk);
      bus.start = noise ? 1'($urandom_range(1)) : 1'b0;
      #1;
      if (bus.done) begin
        seen = 1'b1;
        if (exp_len > 0) chk("done_latency", cyc - start_cyc, exp_len);
        bus.start = 1'b1;
      end
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    chk("busy_after_done", bus.busy, 0);
    chk("done_width", bus.done, 0);
    @(negedge clk);
    #2;
    chk("done_pulses", done_cnt - d0, 1);
    chk("write_count", writes_done, OUT_N * OUT_N);
    chk("sb_data_left", exp_data_q.size(), 0);
    chk("sb_coord_left", exp_row_q.size(), 0);
  endtask

  initial begin
    int d0;
    bit hit;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_win_load", bus.win_load, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_out_we", bus.out_we, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_win_row", bus.win_row, 0);
    chk("rst_win_col", bus.win_col, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Nominal pass with fixed first results and start pulses while busy.
    forced_q.push_back(-6);
    forced_q.push_back(10);
    start_pass();
    wait_done(4 * OUT_N * OUT_N + 1, 1'b1);

    // Three-cycle stall on output (2,3).
    ready_mode = 1;
    stall_left = 3;
    start_pass();
    wait_done(4 * OUT_N * OUT_N + 1 + 3, 1'b0);
    chk("stall_cycles", stall_seen, 3);
    ready_mode = 0;

    // Slow engine with a spurious eng_done in every LOAD.
    eng_delay = 5;
    spur_en   = 1'b1;
    start_pass();
    wait_done(8 * OUT_N * OUT_N + 1, 1'b0);
    spur_en   = 1'b0;

    // Random backpressure.
    eng_delay  = 2;
    ready_mode = 2;
    start_pass();
    wait_done(0, 1'b1);
    ready_mode = 0;

    // Abort in WAIT of output (1,1), then restart.
    eng_delay = 3;
    d0  = done_cnt;
    hit = 1'b0;
    start_pass();
    for (int n = 0; (n < 500) && !hit; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if ((writes_done == OUT_N + 1) && bus.busy && !bus.win_load && !bus.eng_start &&
          !bus.out_we && !bus.done) begin
        hit = 1'b1;
        bus.abort = 1'b1;
      end
    end
    chk("abort_reached_wait", hit, 1);
    @(negedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_out_we", bus.out_we, 0);
    chk("abort_eng_start", bus.eng_start, 0);
    chk("abort_win_row", bus.win_row, 0);
    chk("abort_win_col", bus.win_col, 0);
    repeat (8) @(negedge clk);
    #2;
    chk("abort_no_done", done_cnt - d0, 0);
    flush();
    eng_delay = 1;
    start_pass();
    wait_done(4 * OUT_N * OUT_N + 1, 1'b0);

    // Asynchronous reset while stalled in the first WRITE.
    ready_mode = 3;
    forced_q.push_back(100);
    hit = 1'b0;
    start_pass();
    for (int n = 0; (n < 50) && !hit; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.out_we) hit = 1'b1;
    end
    chk("reached_write", hit, 1);
    chk("pre_reset_data", bus.out_data, ref_post(100));
    #1;
    reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_out_we", bus.out_we, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_out_data", bus.out_data, 0);
    chk("arst_win_row", bus.win_row, 0);
    chk("arst_win_col", bus.win_col, 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
    ready_mode = 0;
    repeat (4) @(negedge clk);
    flush();
    start_pass();
    wait_done(4 * OUT_N * OUT_N + 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
